// File: rtl/imem_dmem_arbiter_if.sv
// Request/response/memory bundle between the core ports, the arbiter and the shared memory.
interface imem_dmem_arbiter_if #(
  parameter int MEM_AW = 12
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [31:0]       if_req_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              if_rsp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [31:0]       d_req_addr;
  logic              d_req_we;
  logic [3:0]        d_req_be;
  logic [31:0]       d_req_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              d_rsp_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_valid, d_req_addr, d_req_we, d_req_be, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_valid, d_req_addr, d_req_we, d_req_be, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one sync-read memory between fetch and load/store: one grant per cycle, response one cycle later.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive denials.
module imem_dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          DEPTH_BYTES  = 16384,
  parameter int          STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  imem_dmem_arbiter_if.slave bus
);

  localparam int          AW    = $clog2(DEPTH_BYTES) - 2;
  localparam logic [31:0] DEPTH = 32'(DEPTH_BYTES);
  localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

  localparam logic [1:0] PORT_NONE = 2'd0;
  localparam logic [1:0] PORT_IF   = 2'd1;
  localparam logic [1:0] PORT_D    = 2'd2;

  logic [3:0]  starve_cnt;
  logic [1:0]  inflight_port;
  logic        inflight_err;
  logic        inflight_we;

  logic        grant_if;
  logic        grant_d;
  logic        granted;
  logic        addr_err;
  logic        issue;
  logic [31:0] req_addr;
  logic [31:0] offset;
  logic        if_own;
  logic        d_own;

  always_comb begin
    grant_d  = rst_n && bus.d_req_valid && !(bus.if_req_valid && (starve_cnt == LIMIT));
    grant_if = rst_n && bus.if_req_valid && !grant_d;
    granted  = grant_if || grant_d;
    req_addr = grant_d ? bus.d_req_addr : bus.if_req_addr;
    // Subtraction wraps, so addresses below the base land far out of range.
    offset   = req_addr - BASE_ADDR;
    addr_err = (req_addr[1:0] != 2'b00) || (offset >= DEPTH);
    issue    = granted && !addr_err;
  end

  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;

  assign bus.mem_en    = issue;
  assign bus.mem_we    = (issue && grant_d && bus.d_req_we) ? bus.d_req_be : 4'b0000;
  assign bus.mem_addr  = issue ? offset[AW+1:2] : '0;
  assign bus.mem_wdata = issue ? bus.d_req_wdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt    <= 4'd0;
      inflight_port <= PORT_NONE;
      inflight_err  <= 1'b0;
      inflight_we   <= 1'b0;
    end else begin
      if (grant_if) begin
        starve_cnt <= 4'd0;
      end else if (bus.if_req_valid && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      inflight_port <= grant_d ? PORT_D : (grant_if ? PORT_IF : PORT_NONE);
      inflight_err  <= granted && addr_err;
      inflight_we   <= grant_d && bus.d_req_we;
    end
  end

  // Gating with rst_n drops a response that is still pending when reset arrives.
  assign if_own = rst_n && (inflight_port == PORT_IF);
  assign d_own  = rst_n && (inflight_port == PORT_D);

  assign bus.if_rsp_valid = if_own;
  assign bus.if_rsp_err   = if_own && inflight_err;
  assign bus.if_rsp_data  = (if_own && !inflight_err) ? bus.mem_rdata : 32'h0;

  assign bus.d_rsp_valid  = d_own;
  assign bus.d_rsp_err    = d_own && inflight_err;
  assign bus.d_rsp_data   = (d_own && !inflight_err && !inflight_we) ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: vector table plus hand sequences for contention and reset.
module tb_imem_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  imem_dmem_arbiter_if #(.MEM_AW(12)) bus ();

  imem_dmem_arbiter #(
    .BASE_ADDR   (32'h8000_0000),
    .DEPTH_BYTES (16384),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: write and registered read on the same edge, old data returned.
  logic [31:0] mem [4096];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[4]     <= 32'hDEAD_BEEF;
      mem[8]     <= 32'hAAAA_AAAA;
      mem[12'hFFF] <= 32'h0BAD_F00D;
      mem_init   <= 1'b1;
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic        iv;   logic [31:0] ia;
    logic        dv;   logic [31:0] da;
    logic        we;   logic [3:0]  be;  logic [31:0] wd;
    logic        e_ir; logic        e_dr;
    logic        e_men; logic [3:0] e_mwe; logic [11:0] e_madr;
    logic        e_iv; logic [31:0] e_id; logic        e_ie;
    logic        e_dv; logic [31:0] e_dd; logic        e_de;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic [31:0] da,
                       input logic we, input logic [3:0] be, input logic [31:0] wd);
    bus.if_req_valid = iv;
    bus.if_req_addr  = ia;
    bus.d_req_valid  = dv;
    bus.d_req_addr   = da;
    bus.d_req_we     = we;
    bus.d_req_be     = be;
    bus.d_req_wdata  = wd;
  endtask

  task automatic cycle_both(input int tag, input logic exp_if);
    @(negedge clk);
    drive(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0020, 1'b0, 4'h0, 32'h0);
    #1;
    chk($sformatf("c%0d if_req_ready", tag), 32'(bus.if_req_ready), 32'(exp_if));
    chk($sformatf("c%0d d_req_ready", tag), 32'(bus.d_req_ready), 32'(!exp_if));
  endtask

  initial begin
    // Each row: inputs this cycle, expected grant/issue this cycle, expected response to the previous row.
    //          iv    ia             dv    da             we    be     wd               ir    dr    men   mwe    madr      iv    id              ie    dv    dd              de
    vecs[0]  = '{1'b1, 32'h8000_0010, 1'b0, 32'h0,         1'b0, 4'h0, 32'h0,          1'b1, 1'b0, 1'b1, 4'h0, 12'h004, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, 32'h0,         1'b1, 32'h8000_0020, 1'b1, 4'h5, 32'h1122_3344,  1'b0, 1'b1, 1'b1, 4'h5, 12'h008, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,          1'b0};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 32'h8000_0020, 1'b0, 4'h0, 32'h0,          1'b0, 1'b1, 1'b1, 4'h0, 12'h008, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0,          1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0002, 1'b0, 32'h0,         1'b0, 4'h0, 32'h0,          1'b1, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 32'h0,          1'b0, 1'b1, 32'hAA22_AA44, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 32'h8000_4000, 1'b0, 4'h0, 32'h0,          1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b1, 32'h0,          1'b1, 1'b0, 32'h0,          1'b0};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 32'h7FFF_FFFC, 1'b0, 4'h0, 32'h0,          1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0,          1'b1};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 32'h8000_3FFC, 1'b0, 4'h0, 32'h0,          1'b0, 1'b1, 1'b1, 4'h0, 12'hFFF, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0,          1'b1};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 32'h8000_0010, 1'b1, 4'h0, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b1, 4'h0, 12'h004, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0BAD_F00D, 1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0010, 1'b0, 32'h0,         1'b0, 4'h0, 32'h0,          1'b1, 1'b0, 1'b1, 4'h0, 12'h004, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0,          1'b0};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 32'h8000_0011, 1'b1, 4'hF, 32'h0,          1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,          1'b0};
    vecs[10] = '{1'b1, 32'h8000_0010, 1'b0, 32'h0,         1'b0, 4'h0, 32'h0,          1'b1, 1'b0, 1'b1, 4'h0, 12'h004, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0,          1'b1};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 4'h0, 32'h0,          1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,          1'b0};
    for (int i = 12; i < NV; i++)
      vecs[i] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000,
                  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};

    // Reset with both ports requesting: nothing may be granted or issued.
    rst_n = 1'b0;
    drive(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0020, 1'b1, 4'hF, 32'h5555_5555);
    repeat (3) @(negedge clk);
    #1;
    chk("reset if_req_ready", 32'(bus.if_req_ready), 32'h0);
    chk("reset d_req_ready", 32'(bus.d_req_ready), 32'h0);
    chk("reset mem_en", 32'(bus.mem_en), 32'h0);
    chk("reset mem_we", 32'(bus.mem_we), 32'h0);
    chk("reset if_rsp_valid", 32'(bus.if_rsp_valid), 32'h0);
    chk("reset d_rsp_valid", 32'(bus.d_rsp_valid), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    chk("post-reset d_rsp_valid", 32'(bus.d_rsp_valid), 32'h0);
    chk("post-reset if_rsp_valid", 32'(bus.if_rsp_valid), 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].we, vecs[i].be, vecs[i].wd);
      #1;
      chk($sformatf("v%0d if_req_ready", i), 32'(bus.if_req_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d d_req_ready", i), 32'(bus.d_req_ready), 32'(vecs[i].e_dr));
      chk($sformatf("v%0d mem_en", i), 32'(bus.mem_en), 32'(vecs[i].e_men));
      chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_mwe));
      if (vecs[i].e_men)
        chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_madr));
      chk($sformatf("v%0d if_rsp_valid", i), 32'(bus.if_rsp_valid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d if_rsp_data", i), bus.if_rsp_data, vecs[i].e_id);
      chk($sformatf("v%0d if_rsp_err", i), 32'(bus.if_rsp_err), 32'(vecs[i].e_ie));
      chk($sformatf("v%0d d_rsp_valid", i), 32'(bus.d_rsp_valid), 32'(vecs[i].e_dv));
      chk($sformatf("v%0d d_rsp_data", i), bus.d_rsp_data, vecs[i].e_dd);
      chk($sformatf("v%0d d_rsp_err", i), 32'(bus.d_rsp_err), 32'(vecs[i].e_de));
    end

    // Continuous contention: D,D,D,D,IF repeating; each response goes to the previous winner.
    begin
      logic prev_if = 1'b0;
      for (int k = 0; k < 10; k++) begin
        cycle_both(k, (k % 5) == 4);
        if (k > 0) begin
          if (prev_if) chk($sformatf("c%0d if_rsp_data", k), bus.if_rsp_data, 32'hDEAD_BEEF);
          else         chk($sformatf("c%0d d_rsp_data", k), bus.d_rsp_data, 32'hAA22_AA44);
          chk($sformatf("c%0d rsp owner", k), 32'(bus.if_rsp_valid), 32'(prev_if));
        end
        prev_if = ((k % 5) == 4);
      end
    end

    // Two denials, idle gap, then only two more denials before fetch must win.
    cycle_both(20, 1'b0);
    cycle_both(21, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    end
    cycle_both(22, 1'b0);
    cycle_both(23, 1'b0);
    cycle_both(24, 1'b1);

    // Reset lands while a load response is pending: it must never appear.
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0020, 1'b0, 4'h0, 32'h0);
    #1;
    chk("rst-mid load grant", 32'(bus.d_req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0020, 1'b0, 4'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("rst-mid%0d d_rsp_valid", k), 32'(bus.d_rsp_valid), 32'h0);
      chk($sformatf("rst-mid%0d if_req_ready", k), 32'(bus.if_req_ready), 32'h0);
      chk($sformatf("rst-mid%0d d_req_ready", k), 32'(bus.d_req_ready), 32'h0);
      chk($sformatf("rst-mid%0d mem_en", k), 32'(bus.mem_en), 32'h0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    chk("rst-mid release d_rsp_valid", 32'(bus.d_rsp_valid), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0020, 1'b0, 4'h0, 32'h0);
    #1;
    chk("after-rst d_req_ready", 32'(bus.d_req_ready), 32'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    chk("after-rst d_rsp_valid", 32'(bus.d_rsp_valid), 32'h1);
    chk("after-rst d_rsp_data", bus.d_rsp_data, 32'hAA22_AA44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
